// File: rtl/branch_predictor_pkg.sv
// Shared constants and PC slicing helpers for the dynamic branch predictor.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_state_e;

  // Fall-through address for a not-taken branch skips the delay slot.
  localparam int DSLOT_OFFSET = 8;

  // Helpers work on a 64-bit widened PC; callers truncate to the field width.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w,
                                         input int tag_w);
    return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] next
);

  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != ST) next = cur + 2'd1;
    end else begin
      if (cur != SNT) next = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Counter table + direct-mapped BTB predictor with ID-stage resolution/training.
// Optional BRANCH_STATS_EN adds resolved-branch and mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter int         TAG_W    = 8,
  parameter int         ADDR_W   = 32,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              id_valid,
  input  logic              id_is_branch,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              id_taken,
  input  logic [ADDR_W-1:0] id_target,
  input  logic              id_pred_taken,
  input  logic [ADDR_W-1:0] id_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispred
`endif
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]        cnt        [DEPTH];
  logic [DEPTH-1:0]  btb_valid;
  logic [TAG_W-1:0]  btb_tag    [DEPTH];
  logic [ADDR_W-1:0] btb_target [DEPTH];

  logic [IDX_W-1:0]  if_idx, id_idx;
  logic [TAG_W-1:0]  if_tag, id_tag;
  logic [1:0]        cnt_next;
  logic              resolve;

  assign if_idx = IDX_W'(pc_index(64'(if_pc), IDX_W));
  assign if_tag = TAG_W'(pc_tag(64'(if_pc), IDX_W, TAG_W));
  assign id_idx = IDX_W'(pc_index(64'(id_pc), IDX_W));
  assign id_tag = TAG_W'(pc_tag(64'(id_pc), IDX_W, TAG_W));

  // Lookup reads the pre-update table; no bypass from the ID-stage write.
  assign pred_taken  = !reset && cnt[if_idx][1] && btb_valid[if_idx] &&
                       (btb_tag[if_idx] == if_tag);
  assign pred_target = pred_taken ? btb_target[if_idx] : '0;

  assign resolve    = !reset && id_valid && id_is_branch;
  assign mispredict = resolve && ((id_taken != id_pred_taken) ||
                                  (id_taken && (id_pred_target != id_target)));

  always_comb begin
    redirect_pc = '0;
    if (mispredict)
      redirect_pc = id_taken ? id_target : id_pc + ADDR_W'(DSLOT_OFFSET);
  end

  sat_counter2 u_sat (
    .cur   (cnt[id_idx]),
    .taken (id_taken),
    .next  (cnt_next)
  );

  // Tag/target storage is left unreset; btb_valid gates every use of it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) cnt[i] <= CNT_INIT;
      btb_valid <= '0;
    end else if (resolve) begin
      cnt[id_idx] <= cnt_next;
      if (id_taken) begin
        btb_valid[id_idx]  <= 1'b1;
        btb_tag[id_idx]    <= id_tag;
        btb_target[id_idx] <= id_target;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (resolve)    stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: driver pushes model expectations, negedge monitor compares.
module tb_branch_predictor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_valid = 1'b0, id_is_branch = 1'b0, id_taken = 1'b0, id_pred_taken = 1'b0;
  logic [31:0] id_pc = '0, id_target = '0, id_pred_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispred;
`endif

  always #5 clock = ~clock;

  branch_predictor dut (
    .clock(clock), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .id_valid(id_valid), .id_is_branch(id_is_branch), .id_pc(id_pc),
    .id_taken(id_taken), .id_target(id_target),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
  );

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] rpc;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: table of integer counters 0..3 plus a BTB, 64 entries.
  int          m_cnt[64];
  bit          m_v[64];
  int          m_tag[64];
  logic [31:0] m_tgt[64];
  int unsigned m_br = 0, m_mp = 0;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int tag_of(logic [31:0] pc);
    return int'((pc / 256) % 256);
  endfunction

  function automatic bit model_pred(logic [31:0] pc, output logic [31:0] tgt);
    int i;
    bit p;
    i = idx_of(pc);
    p = (m_cnt[i] >= 2) && m_v[i] && (m_tag[i] == tag_of(pc));
    tgt = p ? m_tgt[i] : 32'd0;
    return p;
  endfunction

  function automatic bit model_misp();
    if (reset || !id_valid || !id_is_branch) return 1'b0;
    return (id_taken != id_pred_taken) || (id_taken && id_pred_target != id_target);
  endfunction

  // Applies the update implied by the inputs held across this rising edge.
  task automatic commit();
    int i;
    if (reset) begin
      for (int k = 0; k < 64; k++) begin
        m_cnt[k] = 1;
        m_v[k] = 1'b0;
      end
      m_br = 0;
      m_mp = 0;
    end else if (id_valid && id_is_branch) begin
      i = idx_of(id_pc);
      if (model_misp()) m_mp++;
      m_br++;
      if (id_taken) begin
        m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
        m_v[i]   = 1'b1;
        m_tag[i] = tag_of(id_pc);
        m_tgt[i] = id_target;
      end else begin
        m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
      end
    end
  endtask

  task automatic step(input bit r, input logic [31:0] ipc, input bit v, input bit br,
                      input logic [31:0] dpc, input bit tk, input logic [31:0] tgt,
                      input bit ptk, input logic [31:0] ptgt, input string nm);
    exp_t e;
    logic [31:0] t;
    @(posedge clock);
    commit();
    #1;
    reset = r; if_pc = ipc; id_valid = v; id_is_branch = br; id_pc = dpc;
    id_taken = tk; id_target = tgt; id_pred_taken = ptk; id_pred_target = ptgt;
    e.name = nm;
    e.pt   = r ? 1'b0 : model_pred(ipc, t);
    e.ptgt = r ? 32'd0 : t;
    e.mp   = model_misp();
    e.rpc  = e.mp ? (tk ? tgt : dpc + 32'd8) : 32'd0;
    e.sb   = m_br;
    e.sm   = m_mp;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".pred_taken"},  32'(pred_taken),  32'(e.pt));
        chk({e.name, ".pred_target"}, pred_target,      e.ptgt);
        chk({e.name, ".mispredict"},  32'(mispredict),  32'(e.mp));
        chk({e.name, ".redirect_pc"}, redirect_pc,      e.rpc);
`ifdef BRANCH_STATS_EN
        chk({e.name, ".stat_branches"}, stat_branches, e.sb);
        chk({e.name, ".stat_mispred"},  stat_mispred,  e.sm);
`endif
      end
    end
  end

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_1010;
  localparam logic [31:0] TA = 32'h0040_0100;

  initial begin
    logic [31:0] ipc, dpc, tgt, ptgt, t;
    bit v, br, tk, ptk, r;
    int waits;

    step(1, PA, 1, 1, PA, 1, TA, 0, 0, "reset0");
    step(1, PA, 1, 1, PA, 1, TA, 0, 0, "reset_upd");
    step(0, PA, 0, 0, 0, 0, 0, 0, 0, "cold_lookup");
    step(0, PA, 1, 1, PA, 1, TA, 0, 0, "first_taken");
    step(0, PA, 1, 1, PA, 1, TA, 1, TA, "second_taken");
    step(0, PA, 0, 0, 0, 0, 0, 0, 0, "strong_hit");
    step(0, PA, 1, 1, PA, 0, TA, 1, TA, "nt_on_strong");
    step(0, PA, 0, 0, 0, 0, 0, 0, 0, "after_nt");
    step(0, PB, 0, 0, 0, 0, 0, 0, 0, "alias_tag");
    step(0, PA, 0, 1, PA, 1, 32'h0040_0200, 0, 0, "idv0");
    step(0, PA, 0, 0, 0, 0, 0, 0, 0, "idv0_after");
    step(0, PA, 1, 0, PA, 1, 32'h0040_0200, 0, 0, "not_branch");
    step(0, PA, 1, 1, PA, 0, TA, 1, TA, "same_idx_a");
    step(0, PA, 1, 1, PA, 0, TA, 0, 0, "same_idx_b");
    step(0, PA, 0, 0, 0, 0, 0, 0, 0, "same_idx_c");
    step(1, PA, 0, 0, 0, 0, 0, 0, 0, "reset_mid");
    step(0, PA, 0, 0, 0, 0, 0, 0, 0, "post_reset");

    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 99) < 2);
      ipc = 32'h0040_0000 | ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) ? 32'h1000 : 32'h0);
      dpc = 32'h0040_0000 | ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) ? 32'h1000 : 32'h0);
      tgt = TA + ($urandom_range(0, 3) << 4);
      v   = ($urandom_range(0, 9) != 0);
      br  = ($urandom_range(0, 9) < 8);
      tk  = $urandom_range(0, 1);
      if ($urandom_range(0, 9) < 7) begin
        ptk  = model_pred(dpc, t);
        ptgt = t;
      end else begin
        ptk  = $urandom_range(0, 1);
        ptgt = TA + ($urandom_range(0, 3) << 4);
      end
      step(r, ipc, v, br, dpc, tk, tgt, ptk, ptgt, "rand");
    end

    waits = 0;
    while (q.size() > 0 && waits < 10) begin
      @(posedge clock);
      waits++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
